// File: rtl/vr16_pkg.sv
// Shared types for the VR16 memory arbiter: FSM states and port identifiers.
package vr16_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Winner pick between fetch and data requesters; MEM_ARB_ROUND_ROBIN_EN selects round-robin.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module arb_select
    import vr16_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_owner,
`endif
    output logic any_req,
    output logic winner
);

    assign any_req = if_req | d_req;

    always_comb begin
        winner = PORT_D;
        if (if_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            winner = ~last_owner;
`else
            winner = PORT_D;
`endif
        end else if (if_req) begin
            winner = PORT_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port VR16 memory between fetch (port 0) and load/store (port 1); MEM_ARB_ROUND_ROBIN_EN enables round-robin.
// Latency: grant same cycle as request, done/err one cycle after mem_ack or budget expiry.
// Backpressure: requests hold until their gnt; losers simply wait for the next IDLE cycle.
module mem_arbiter
    import vr16_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              if_gnt,
    output logic              d_gnt,
    output logic              if_done,
    output logic              d_done,
    output logic              if_err,
    output logic              d_err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state;
    logic              owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              any_req;
    logic              winner;
    logic              grant;
    logic              timeout_hit;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_owner;
`endif

    arb_select u_arb_select (
        .if_req     (if_req),
        .d_req      (d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_owner (last_owner),
`endif
        .any_req    (any_req),
        .winner     (winner)
    );

    // Gated by reset so a request held through reset is not granted without being latched.
    assign grant       = (state == IDLE) && any_req && !reset;
    assign if_gnt      = grant && (winner == PORT_IF);
    assign d_gnt       = grant && (winner == PORT_D);
    assign busy        = (state != IDLE);
    assign mem_req     = (state == ACCESS);
    assign mem_we      = mem_req && we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= PORT_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            rdata      <= '0;
            if_done    <= 1'b0;
            d_done     <= 1'b0;
            if_err     <= 1'b0;
            d_err      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner <= PORT_D;
`endif
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            if_err  <= 1'b0;
            d_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= winner;
                        cnt   <= '0;
                        state <= ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_owner <= winner;
`endif
                        if (winner == PORT_D) begin
                            addr_q  <= d_addr;
                            we_q    <= d_we;
                            wdata_q <= d_wdata;
                        end else begin
                            addr_q  <= if_addr;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // An ack in the final budget cycle still completes the access.
                    if (mem_ack) begin
                        rdata   <= mem_rdata;
                        if_done <= (owner == PORT_IF);
                        d_done  <= (owner == PORT_D);
                        state   <= IDLE;
                    end else if (timeout_hit) begin
                        if_err <= (owner == PORT_IF);
                        d_err  <= (owner == PORT_D);
                        state  <= IDLE;
                    end else if (TIMEOUT > 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with TIMEOUT=4 against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, d_gnt, if_done, d_done, if_err, d_err;
    logic [15:0] rdata;
    logic        busy, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .if_gnt(if_gnt), .d_gnt(d_gnt), .if_done(if_done), .d_done(d_done),
        .if_err(if_err), .d_err(d_err), .rdata(rdata), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Reference model state: last granted port and the requester-visible read data.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic exp_last;
`endif
    logic [15:0] exp_rdata;

    function automatic logic exp_pick(input logic ir, input logic dr);
        if (ir && dr) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return ~exp_last;
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    task automatic model_grant(input logic w, input logic acked, input logic [15:0] rv);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_last = w;
`endif
        if (acked) exp_rdata = rv;
    endtask

    task automatic model_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_last = 1'b1;
`endif
        exp_rdata = 16'h0000;
    endtask

    // Observations of one access, captured by drive_access.
    logic        obs_gi, obs_gd, obs_we, obs_hold, obs_busy_acc, obs_mreq_end, obs_busy_end;
    logic [15:0] obs_addr, obs_wd, obs_rdata;
    logic [3:0]  obs_flags;
    int          obs_reqc, obs_end;

    // Drives one request set from the negedge of an IDLE cycle and plays the memory;
    // ack_at is the ACCESS cycle (1-based) in which mem_ack is given, 0 for never.
    task automatic drive_access(input logic ir, input logic dr, input logic we,
                                input logic [15:0] ia, input logic [15:0] da,
                                input logic [15:0] wd, input int ack_at,
                                input logic [15:0] rv);
        int c;
        if_req = ir; if_addr = ia;
        d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
        #1;
        obs_gi = if_gnt;
        obs_gd = d_gnt;
        @(posedge clk);
        @(negedge clk);
        if (obs_gi) if_req = 1'b0;
        if (obs_gd) d_req = 1'b0;
        obs_reqc = 0; obs_end = 0; obs_hold = 1'b1; obs_flags = 4'b0000;
        obs_busy_acc = busy;
        c = 1;
        while (obs_end == 0 && c <= 20) begin
            if (mem_req) begin
                if (obs_reqc == 0) begin
                    obs_addr = mem_addr; obs_we = mem_we; obs_wd = mem_wdata;
                end else if (mem_addr !== obs_addr || mem_we !== obs_we || mem_wdata !== obs_wd) begin
                    obs_hold = 1'b0;
                end
                obs_reqc++;
            end
            if (if_done || d_done || if_err || d_err) begin
                obs_end = c;
                obs_flags = {if_done, d_done, if_err, d_err};
                obs_rdata = rdata;
                obs_mreq_end = mem_req;
                obs_busy_end = busy;
            end else begin
                mem_ack = (c == ack_at);
                mem_rdata = (c == ack_at) ? rv : 16'($urandom);
                @(negedge clk);
                c++;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_chk++;
        if ({busy, mem_req, mem_we, if_gnt, d_gnt} !== 5'b0) $display("FAIL reset_ctrl got %b want 00000", {busy, mem_req, mem_we, if_gnt, d_gnt});
        else n_pass++;
        n_chk++;
        if ({if_done, d_done, if_err, d_err} !== 4'b0) $display("FAIL reset_pulses got %b want 0000", {if_done, d_done, if_err, d_err});
        else n_pass++;
        n_chk++;
        if (rdata !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) $display("FAIL reset_data got rdata=%h addr=%h wdata=%h want 0", rdata, mem_addr, mem_wdata);
        else n_pass++;
    endtask

    task automatic test_fetch();
        drive_access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h0, 2, 16'hBEEF);
        n_chk++;
        if ({obs_gi, obs_gd} !== 2'b10) $display("FAIL fetch_gnt got %b want 10", {obs_gi, obs_gd});
        else n_pass++;
        n_chk++;
        if (obs_addr !== 16'h0010 || obs_we !== 1'b0 || obs_busy_acc !== 1'b1) $display("FAIL fetch_mem got addr=%h we=%b busy=%b want 0010 0 1", obs_addr, obs_we, obs_busy_acc);
        else n_pass++;
        n_chk++;
        if (obs_reqc !== 2 || obs_end !== 3) $display("FAIL fetch_timing got reqc=%0d end=%0d want 2 3", obs_reqc, obs_end);
        else n_pass++;
        n_chk++;
        if (obs_flags !== 4'b1000 || obs_rdata !== 16'hBEEF) $display("FAIL fetch_done got flags=%b rdata=%h want 1000 beef", obs_flags, obs_rdata);
        else n_pass++;
        n_chk++;
        if (obs_busy_end !== 1'b0 || obs_mreq_end !== 1'b0) $display("FAIL fetch_idle got busy=%b mem_req=%b want 0 0", obs_busy_end, obs_mreq_end);
        else n_pass++;
        model_grant(1'b0, 1'b1, 16'hBEEF);
    endtask

    task automatic test_write();
        drive_access(1'b0, 1'b1, 1'b1, 16'h0, 16'h0200, 16'h1234, 3, 16'h5A5A);
        n_chk++;
        if ({obs_gi, obs_gd} !== 2'b01) $display("FAIL write_gnt got %b want 01", {obs_gi, obs_gd});
        else n_pass++;
        n_chk++;
        if (obs_addr !== 16'h0200 || obs_we !== 1'b1 || obs_wd !== 16'h1234 || obs_hold !== 1'b1)
            $display("FAIL write_mem got addr=%h we=%b wdata=%h hold=%b want 0200 1 1234 1", obs_addr, obs_we, obs_wd, obs_hold);
        else n_pass++;
        n_chk++;
        if (obs_reqc !== 3 || obs_end !== 4 || obs_flags !== 4'b0100)
            $display("FAIL write_done got reqc=%0d end=%0d flags=%b want 3 4 0100", obs_reqc, obs_end, obs_flags);
        else n_pass++;
        model_grant(1'b1, 1'b1, 16'h5A5A);
    endtask

    task automatic test_simultaneous();
        logic ir, dr, w;
        logic [15:0] rv;
        ir = 1'b1; dr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) dr = 1'b1;  // data requester fires again right away
            if (!ir && !dr) break;
            w = exp_pick(ir, dr);
            rv = 16'($urandom);
            drive_access(ir, dr, 1'b0, 16'h0100 + 16'(k), 16'h0300 + 16'(k), 16'h0, 1, rv);
            n_chk++;
            if ({obs_gi, obs_gd} !== {~w, w}) $display("FAIL simul_gnt%0d got %b want %b", k, {obs_gi, obs_gd}, {~w, w});
            else n_pass++;
            n_chk++;
            if (obs_flags !== {~w, w, 2'b00} || obs_rdata !== rv)
                $display("FAIL simul_done%0d got flags=%b rdata=%h want %b %h", k, obs_flags, obs_rdata, {~w, w, 2'b00}, rv);
            else n_pass++;
            model_grant(w, 1'b1, rv);
            if (w) dr = 1'b0; else ir = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_timeout();
        logic [15:0] rv;
        drive_access(1'b0, 1'b1, 1'b0, 16'h0, 16'h0777, 16'h0, 0, 16'h0);
        n_chk++;
        if (obs_reqc !== TO || obs_end !== TO + 1) $display("FAIL timeout_timing got reqc=%0d end=%0d want %0d %0d", obs_reqc, obs_end, TO, TO + 1);
        else n_pass++;
        n_chk++;
        if (obs_flags !== 4'b0001 || obs_rdata !== exp_rdata) $display("FAIL timeout_err got flags=%b rdata=%h want 0001 %h", obs_flags, obs_rdata, exp_rdata);
        else n_pass++;
        n_chk++;
        if (obs_busy_end !== 1'b0 || obs_mreq_end !== 1'b0) $display("FAIL timeout_idle got busy=%b mem_req=%b want 0 0", obs_busy_end, obs_mreq_end);
        else n_pass++;
        model_grant(1'b1, 1'b0, 16'h0);
        rv = 16'hC0DE;
        drive_access(1'b1, 1'b0, 1'b0, 16'h0888, 16'h0, 16'h0, TO, rv);
        n_chk++;
        if (obs_flags !== 4'b1000 || obs_end !== TO + 1 || obs_rdata !== rv)
            $display("FAIL ack_vs_timeout got flags=%b end=%0d rdata=%h want 1000 %0d %h", obs_flags, obs_end, obs_rdata, TO + 1, rv);
        else n_pass++;
        model_grant(1'b0, 1'b1, rv);
    endtask

    task automatic test_ack_idle();
        logic seen;
        seen = 1'b0;
        if_req = 1'b0; d_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            if (busy || mem_req || if_done || d_done || if_err || d_err) seen = 1'b1;
        end
        mem_ack = 1'b0;
        n_chk++;
        if (seen !== 1'b0 || rdata !== exp_rdata) $display("FAIL ack_idle got activity=%b rdata=%h want 0 %h", seen, rdata, exp_rdata);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        if_req = 1'b1; if_addr = 16'h0044;
        @(posedge clk);
        @(negedge clk);
        if_req = 1'b0;
        n_chk++;
        if (mem_req !== 1'b1) $display("FAIL midreset_pre got mem_req=%b want 1", mem_req);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if (mem_req !== 1'b0 || busy !== 1'b0) $display("FAIL midreset_drop got mem_req=%b busy=%b want 0 0", mem_req, busy);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (if_done || d_done || if_err || d_err) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0 || rdata !== 16'h0) $display("FAIL midreset_quiet got pulse=%b rdata=%h want 0 0000", seen, rdata);
        else n_pass++;
        drive_access(1'b1, 1'b0, 1'b0, 16'h0046, 16'h0, 16'h0, 1, 16'h7777);
        n_chk++;
        if (obs_gi !== 1'b1 || obs_addr !== 16'h0046 || obs_flags !== 4'b1000 || obs_rdata !== 16'h7777)
            $display("FAIL midreset_fresh got gnt=%b addr=%h flags=%b rdata=%h want 1 0046 1000 7777", obs_gi, obs_addr, obs_flags, obs_rdata);
        else n_pass++;
        model_grant(1'b0, 1'b1, 16'h7777);
    endtask

    task automatic test_random();
        logic pi, pd, ir, dr, we, w, acked;
        logic [15:0] ia, da, wd, rv;
        int ack;
        pi = 1'b0; pd = 1'b0;
        ia = '0; da = '0; wd = '0; we = 1'b0;
        for (int it = 0; it < 30; it++) begin
            ir = pi | 1'($urandom_range(0, 1));
            dr = pd | 1'($urandom_range(0, 1));
            if (!ir && !dr) ir = 1'b1;
            if (!pi) ia = 16'($urandom);
            if (!pd) begin da = 16'($urandom); wd = 16'($urandom); we = 1'($urandom_range(0, 1)); end
            ack = $urandom_range(1, TO + 1);
            acked = (ack <= TO);
            rv = 16'($urandom);
            w = exp_pick(ir, dr);
            drive_access(ir, dr, we, ia, da, wd, ack, rv);
            n_chk++;
            if ({obs_gi, obs_gd} !== {~w, w}) $display("FAIL rnd%0d_gnt got %b want %b", it, {obs_gi, obs_gd}, {~w, w});
            else n_pass++;
            n_chk++;
            if (obs_addr !== (w ? da : ia) || obs_we !== (w & we) || obs_wd !== (w ? wd : 16'h0) || obs_hold !== 1'b1)
                $display("FAIL rnd%0d_mem got addr=%h we=%b wdata=%h hold=%b want %h %b %h 1", it, obs_addr, obs_we, obs_wd, obs_hold,
                         (w ? da : ia), (w & we), (w ? wd : 16'h0));
            else n_pass++;
            n_chk++;
            if (obs_reqc !== (acked ? ack : TO) || obs_end !== (acked ? ack + 1 : TO + 1))
                $display("FAIL rnd%0d_timing got reqc=%0d end=%0d want %0d %0d", it, obs_reqc, obs_end, (acked ? ack : TO), (acked ? ack + 1 : TO + 1));
            else n_pass++;
            n_chk++;
            if (obs_flags !== (acked ? {~w, w, 2'b00} : {2'b00, ~w, w}))
                $display("FAIL rnd%0d_flags got %b want %b", it, obs_flags, (acked ? {~w, w, 2'b00} : {2'b00, ~w, w}));
            else n_pass++;
            model_grant(w, acked, rv);
            n_chk++;
            if (obs_rdata !== exp_rdata) $display("FAIL rnd%0d_rdata got %h want %h", it, obs_rdata, exp_rdata);
            else n_pass++;
            pi = ir && w;
            pd = dr && !w;
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_simultaneous();
        test_timeout();
        test_ack_idle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
